// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined Wallace-tree multiplier: operand mode,
// reduction-tree sizing and pipeline-register placement helpers.
package mul_pkg;

  typedef enum logic {
    MODE_UNSIGNED = 1'b0,
    MODE_SIGNED   = 1'b1
  } mul_mode_e;

  localparam int W_DEFAULT  = 8;
  localparam int PW_DEFAULT = 2 * W_DEFAULT;

  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

  // Rows left after one 3:2 level: every full group of three becomes two.
  function automatic int reduce_once(input int n);
    return 2 * (n / 3) + n % 3;
  endfunction

  function automatic int wallace_levels(input int w);
    int n;
    int l;
    n = w;
    l = 0;
    while (n > 2) begin
      n = reduce_once(n);
      l++;
    end
    return l;
  endfunction

  function automatic int rows_after(input int w, input int levels);
    int n;
    n = w;
    for (int i = 0; i < levels; i++) begin
      if (n > 2) n = reduce_once(n);
    end
    return n;
  endfunction

  // Level index after which internal register i sits; L+1 means after the CPA.
  function automatic int boundary_level(input int w, input int ps, input int i);
    int l;
    l = wallace_levels(w);
    if (ps - 1 > l) return (i <= l) ? i : l + 1;
    return (i * l + ps - 1) / ps;
  endfunction

  function automatic int regs_at(input int w, input int ps, input int lvl);
    int cnt;
    cnt = 0;
    for (int i = 1; i < ps; i++) begin
      if (boundary_level(w, ps, i) == lvl) cnt++;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/csa_row.sv
// One row of 3:2 full-adder cells over column-aligned vectors; the carry
// vector comes out already shifted one column left, truncated to N bits.
module csa_row #(
  parameter int N = 16
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] z,
  output logic [N-1:0] sum,
  output logic [N-1:0] carry
);

  assign sum   = x ^ y ^ z;
  assign carry = {(x[N-2:0] & y[N-2:0]) | (x[N-2:0] & z[N-2:0]) | (y[N-2:0] & z[N-2:0]),
                  1'b0};

endmodule

// File: rtl/wallace_mul_pipe.sv
// Pipelined Wallace-tree multiplier, unsigned or Baugh-Wooley signed per
// transaction, with a valid/ready handshake and a globally stalled pipeline.
module wallace_mul_pipe
  import mul_pkg::*;
#(
  parameter int W           = W_DEFAULT,
  parameter int PIPE_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic            sgn,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  p
);

  localparam int PW   = prod_width(W);
  localparam int L    = wallace_levels(W);
  localparam int POST = regs_at(W, PIPE_STAGES, L + 1);

  mul_mode_e mode;
  logic      adv;

  logic [W-1:0][PW-1:0] pp;
  logic [W-1:0][PW-1:0] lv_d [0:L];
  logic [W-1:0][PW-1:0] lv_q [0:L];
  logic [L:0]           v_d;
  logic [L:0]           v_q;

  logic [PW-1:0] cpa;
  logic [PW-1:0] fin_p;
  logic          fin_v;

  assign in_ready = !out_valid || out_ready;
  assign adv      = in_ready;
  assign mode     = mul_mode_e'(sgn);

  // Signed mode inverts the cross terms against the sign bits and injects
  // ones at columns W and 2W-1; row 0 has those columns free.
  always_comb begin
    // NOTE: pp gets a full default first so no path leaves a bit unassigned (no latch).
    pp = '0;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        pp[i][i+j] = (a[j] & b[i]) ^ ((mode == MODE_SIGNED) && ((i == W - 1) != (j == W - 1)));
      end
    end
    if (mode == MODE_SIGNED) begin
      pp[0][W]    = 1'b1;
      pp[0][PW-1] = 1'b1;
    end
  end

  assign lv_d[0] = pp;
  assign v_d[0]  = in_valid;

  for (genvar s = 0; s <= L; s++) begin : g_bnd
    if (regs_at(W, PIPE_STAGES, s) > 0) begin : g_reg
      logic [W-1:0][PW-1:0] rows_r;
      logic                 valid_r;

      always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every stage samples pre-edge values.
        if (rst)      valid_r <= 1'b0;
        else if (adv) valid_r <= v_d[s];
      end

      // NOTE: row data is not reset; the valid bit alone says whether it means anything.
      always_ff @(posedge clk) begin
        if (adv) rows_r <= lv_d[s];
      end

      assign lv_q[s] = rows_r;
      assign v_q[s]  = valid_r;
    end else begin : g_thru
      assign lv_q[s] = lv_d[s];
      assign v_q[s]  = v_d[s];
    end
  end

  for (genvar s = 1; s <= L; s++) begin : g_lvl
    localparam int N = rows_after(W, s - 1);
    localparam int G = N / 3;
    localparam int R = N % 3;

    for (genvar g = 0; g < G; g++) begin : g_csa
      logic [PW-1:0] s_v;
      logic [PW-1:0] c_v;

      csa_row #(.N(PW)) u_csa (
        .x     (lv_q[s-1][3*g]),
        .y     (lv_q[s-1][3*g+1]),
        .z     (lv_q[s-1][3*g+2]),
        .sum   (s_v),
        .carry (c_v)
      );

      assign lv_d[s][2*g]   = s_v;
      assign lv_d[s][2*g+1] = c_v;
    end

    for (genvar r = 0; r < R; r++) begin : g_pass
      assign lv_d[s][2*G+r] = lv_q[s-1][3*G+r];
    end

    for (genvar k = 2 * G + R; k < W; k++) begin : g_zero
      assign lv_d[s][k] = '0;
    end

    assign v_d[s] = v_q[s-1];
  end

  assign cpa = lv_q[L][0] + lv_q[L][1];

  // Registers that do not fit between reduction levels delay the finished sum.
  if (POST > 0) begin : g_post
    logic [PW-1:0]   xp [0:POST-1];
    logic [POST-1:0] xv;

    always_ff @(posedge clk) begin
      if (rst) begin
        xv <= '0;
      end else if (adv) begin
        xv[0] <= v_q[L];
        for (int k = 1; k < POST; k++) xv[k] <= xv[k-1];
      end
    end

    always_ff @(posedge clk) begin
      if (adv) begin
        xp[0] <= cpa;
        for (int k = 1; k < POST; k++) xp[k] <= xp[k-1];
      end
    end

    assign fin_p = xp[POST-1];
    assign fin_v = xv[POST-1];
  end else begin : g_nopost
    assign fin_p = cpa;
    assign fin_v = v_q[L];
  end

  // p only loads real products, so it stays zero after reset until one arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      p         <= '0;
    end else if (adv) begin
      out_valid <= fin_v;
      if (fin_v) p <= fin_p;
    end
  end

endmodule

// File: tb/tb_wallace_mul_pipe.sv
// Scoreboard bench: four multipliers (PIPE_STAGES 1..4) share stimulus; each
// has its own queue of expected products checked against an arithmetic model.
module tb_wallace_mul_pipe;
  localparam int W    = 8;
  localparam int NDUT = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             sgn;
  logic             out_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [NDUT-1:0]  in_ready;
  logic [NDUT-1:0]  out_valid;
  logic [2*W-1:0]   p [NDUT];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit timing_on = 1'b1;

  typedef struct {
    logic [2*W-1:0] prod;
    int             due;
    bit             timed;
  } exp_t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    wallace_mul_pipe #(.W(W), .PIPE_STAGES(k + 1)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready[k]),
      .a         (a),
      .b         (b),
      .sgn       (sgn),
      .out_valid (out_valid[k]),
      .out_ready (out_ready),
      .p         (p[k])
    );
  end

  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
    longint xv;
    longint yv;
    xv = s ? longint'($signed(x)) : longint'(x);
    yv = s ? longint'($signed(y)) : longint'(y);
    return (2*W)'(xv * yv);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar k = 0; k < NDUT; k++) begin : g_sb
    exp_t q[$];
    int   pending = 0;
    bit   held = 1'b0;
    logic [2*W-1:0] held_p;

    always @(negedge clk) begin
      exp_t e;
      if (rst) begin
        q.delete();
        held = 1'b0;
      end else begin
        check($sformatf("in_ready[ps=%0d]", k + 1), 64'(in_ready[k]),
              64'(!out_valid[k] || out_ready));
        if (held) begin
          check($sformatf("stall out_valid[ps=%0d]", k + 1), 64'(out_valid[k]), 64'(1));
          check($sformatf("stall p stable[ps=%0d]", k + 1), 64'(p[k]), 64'(held_p));
        end
        held   = out_valid[k] && !out_ready;
        held_p = p[k];
        if (out_valid[k] && out_ready) begin
          if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected product[ps=%0d]: got %0h, expected no output", k + 1, p[k]);
          end else begin
            e = q.pop_front();
            check($sformatf("product[ps=%0d]", k + 1), 64'(p[k]), 64'(e.prod));
            if (e.timed) check($sformatf("latency[ps=%0d]", k + 1), 64'(cyc), 64'(e.due));
          end
        end
        if (in_valid && in_ready[k]) begin
          e.prod  = model(a, b, sgn);
          e.due   = cyc + k + 1;
          e.timed = timing_on;
          q.push_back(e);
        end
      end
      pending = q.size();
    end
  end

  function automatic int total_pending();
    return g_sb[0].pending + g_sb[1].pending + g_sb[2].pending + g_sb[3].pending;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (total_pending() == 0) break;
      step();
    end
    step();
  endtask

  task automatic directed(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic s, input logic [2*W-1:0] exp);
    bit found;
    a = av; b = bv; sgn = s; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (out_valid[1]) begin
        found = 1'b1;
        check(name, 64'(p[1]), 64'(exp));
      end
    end
    check({name, " seen"}, 64'(found), 64'(1));
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sgn = 1'b0;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("reset out_valid[ps=%0d]", k + 1), 64'(out_valid[k]), 64'(0));
      check($sformatf("reset p[ps=%0d]", k + 1), 64'(p[k]), 64'(0));
      check($sformatf("reset in_ready[ps=%0d]", k + 1), 64'(in_ready[k]), 64'(1));
    end
    step();

    directed("u ff*ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    directed("u 00*5a", 8'h00, 8'h5A, 1'b0, 16'h0000);
    directed("s 80*80", 8'h80, 8'h80, 1'b1, 16'h4000);
    directed("s ff*01", 8'hFF, 8'h01, 1'b1, 16'hFFFF);
    directed("s 7f*80", 8'h7F, 8'h80, 1'b1, 16'hC080);
    drain();

    // Back-to-back streaming, sgn alternating.
    for (int i = 0; i < 16; i++) begin
      a = W'($urandom); b = W'($urandom); sgn = i[0]; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    drain();

    // Bubble pattern 1,0,1,1,0.
    for (int i = 0; i < 5; i++) begin
      a = W'($urandom); b = W'($urandom); sgn = W'($urandom) > 8'd127;
      in_valid = (i == 0 || i == 2 || i == 3);
      step();
    end
    in_valid = 1'b0;
    drain();

    // Backpressure: hold the consumer off for five cycles.
    timing_on = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a = W'($urandom); b = W'($urandom); sgn = i[0]; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Random valid and ready.
    for (int i = 0; i < 300; i++) begin
      a = W'($urandom); b = W'($urandom); sgn = ($urandom % 2) == 1;
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    timing_on = 1'b1;

    // Reset with two transactions in flight.
    for (int i = 0; i < 2; i++) begin
      a = W'($urandom); b = W'($urandom); sgn = i[0]; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("mid reset out_valid[ps=%0d]", k + 1), 64'(out_valid[k]), 64'(0));
      check($sformatf("mid reset p[ps=%0d]", k + 1), 64'(p[k]), 64'(0));
    end
    step();
    for (int i = 0; i < 8; i++) step();

    for (int i = 0; i < 16; i++) begin
      a = W'($urandom); b = W'($urandom); sgn = ~i[0]; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    drain();
    for (int i = 0; i < 6; i++) step();

    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("all drained[ps=%0d]", k + 1), 64'(k == 0 ? g_sb[0].pending :
                                                          k == 1 ? g_sb[1].pending :
                                                          k == 2 ? g_sb[2].pending :
                                                                   g_sb[3].pending), 64'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wallace_mul_pipe.md
Name: wallace_mul_pipe

Overview:
Parametrised, pipelined Wallace-tree multiplier for the multiplier datapath. It takes two W-bit operands and produces a 2W-bit product. The product is computed as partial products, then 3:2/2:2 carry-save reduction using full/half-adder cells, then a final carry-propagate add. Pipeline registers sit between reduction levels, with a valid/ready handshake on both sides. A per-transaction mode bit selects an unsigned or signed (Baugh-Wooley) product.

Parameters:
W, 8, operand width in bits; legal range 4..32.
PIPE_STAGES, 2, number of register boundaries from input to output; legal range 1..4.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands present
in_ready  output  1  block can accept operands this cycle
a  input  W  multiplicand
b  input  W  multiplier
sgn  input  1  1 = two's-complement operands, 0 = unsigned
out_valid  output  1  product present
out_ready  input  1  consumer accepts product this cycle
p  output  2W  product; sign-extended to 2W when sgn=1

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset: at a clk edge with rst=1:
  - all stage valid bits clear; out_valid=0.
  - p=0.
  - in-flight operands are discarded; no partial result is ever emitted.
  - in_ready=1 from the cycle after reset.
- Accept rule: a transaction is accepted at an edge where in_valid=1 and in_ready=1. a, b and sgn are sampled together.
- Stall: in_ready = !out_valid || out_ready. When in_ready=0 the whole pipeline holds: every register keeps its value and no bubble is collapsed.
- Latency: a transaction accepted at edge k is held in the output register from edge k+PIPE_STAGES-1. out_valid is 1 in the following cycle.
  - With PIPE_STAGES=1 there is a combinational multiply into the output register.
- Throughput: one product per cycle when out_ready is held at 1.
- Valid propagation:
  - Each stage register carries a valid bit.
  - Bubbles (in_valid=0) propagate as invalid stages.
  - Data registers may load don't-care values on bubbles. p must not change while out_valid=1 and out_ready=0.
- Output hold: p and out_valid hold until out_ready=1. Simultaneous accept and drain in the same cycle is legal and loses nothing.
- Arithmetic:
  - sgn=0: p = a*b, exact, modulo 2^(2W) (never overflows).
  - sgn=1: p = signed(a)*signed(b) as a 2W-bit two's-complement value. This is done by Baugh-Wooley partial-product inversion plus constant-one injection at columns W and 2W-1.
  - The exact product for (-2^(W-1))^2 is required.
- Reduction schedule:
  - Wallace levels L = number of 3:2 levels needed to reduce W rows to 2 rows.
  - Registers are placed after levels ceil(i*L/PIPE_STAGES) for i=1..PIPE_STAGES-1.
  - The final CPA is combinational before the output register.
  - If PIPE_STAGES-1 > L, the extra registers go after the CPA.
- sgn travels with its transaction through every stage.

Decomposition:
- Shared package mul_pkg:
  - function wallace_levels(W) returning L.
  - stage-boundary placement function.
  - localparam PW=2*W.
- Sub-module csa_row: a parametrised row of 3:2 full-adder cells, with half-adder cells on 2-bit columns. It maps three column-aligned vectors to sum/carry vectors. The top-level block instantiates one csa_row per reduction level through generate loops.

Test Plan:
- W=8, PIPE_STAGES=2, out_ready=1, sgn=0:
  - a=0xFF, b=0xFF -> p=0xFE01, out_valid one cycle after the edge following acceptance.
  - a=0, b=0x5A -> p=0x0000.
- sgn=1, W=8:
  - a=0x80, b=0x80 -> p=0x4000.
  - a=0xFF, b=0x01 -> p=0xFFFF.
  - a=0x7F, b=0x80 -> p=0xC080.
- Back-to-back streaming of 16 random pairs with sgn alternating: 16 consecutive correct products, no gaps, matching a reference model, across PIPE_STAGES=1..4.
- Backpressure:
  - hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 once out_valid=1; p stable.
  - release -> all products emitted in order, none dropped or duplicated.
- Reset mid-operation: two transactions in flight, rst=1 for one cycle -> out_valid=0 and p=0 next cycle; no stale product ever appears.
- Bubbles: in_valid pattern 1,0,1,1,0 -> out_valid pattern 1,0,1,1,0 delayed by the latency, with correct products.
